// File: rtl/tod_counter.sv
// Time-of-day counter: seconds / minutes / hours advanced by an upstream
// one-cycle seconds tick, with field load, per-field adjust, run/pause,
// 12/24-hour display encoding and registered carry pulses.
module tod_counter #(
  parameter int unsigned SEC_BIT  = 6,
  parameter int unsigned MIN_BIT  = 6,
  parameter int unsigned HOUR_BIT = 5,
  parameter int unsigned SEC_MAX  = 59,
  parameter int unsigned MIN_MAX  = 59,
  parameter int unsigned HOUR_MAX = 23,
  localparam int unsigned SM_BIT  = (SEC_BIT > MIN_BIT) ? SEC_BIT : MIN_BIT,
  localparam int unsigned VAL_BIT = (SM_BIT > HOUR_BIT) ? SM_BIT : HOUR_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_in,
  input  logic                run,
  input  logic                mode_12h,
  input  logic                set_en,
  input  logic [1:0]          set_sel,
  input  logic [VAL_BIT-1:0]  set_val,
  input  logic                adj_inc,
  output logic [SEC_BIT-1:0]  sec,
  output logic [MIN_BIT-1:0]  minute,
  output logic [HOUR_BIT-1:0] hour,
  output logic [HOUR_BIT-1:0] hour_disp,
  output logic                pm,
  output logic                min_tick,
  output logic                hour_tick,
  output logic                day_tick,
  output logic                set_err
);

  localparam logic [SEC_BIT-1:0]  SEC_LAST  = SEC_BIT'(SEC_MAX);
  localparam logic [MIN_BIT-1:0]  MIN_LAST  = MIN_BIT'(MIN_MAX);
  localparam logic [HOUR_BIT-1:0] HOUR_LAST = HOUR_BIT'(HOUR_MAX);
  localparam int unsigned         HALF      = (HOUR_MAX + 1) / 2;
  localparam logic [HOUR_BIT-1:0] HALF_H    = HOUR_BIT'(HALF);

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;

  logic [SEC_BIT-1:0]  r_sec;
  logic [MIN_BIT-1:0]  r_min;
  logic [HOUR_BIT-1:0] r_hour;
  logic                r_min_tick;
  logic                r_hour_tick;
  logic                r_day_tick;
  logic                r_set_err;

  logic                w_adv;
  logic                w_sec_wrap;
  logic                w_min_wrap;
  logic                w_hour_wrap;
  logic [SEC_BIT-1:0]  w_sec_inc;
  logic [MIN_BIT-1:0]  w_min_inc;
  logic [HOUR_BIT-1:0] w_hour_inc;
  logic [SEC_BIT-1:0]  w_sec_val;
  logic [MIN_BIT-1:0]  w_min_val;
  logic [HOUR_BIT-1:0] w_hour_val;
  logic                w_load_ok;
  logic [HOUR_BIT-1:0] w_h12;

  // A tick is dropped (not deferred) whenever load or adjust claims the cycle.
  assign w_adv = tick_in & run & ~set_en & ~adj_inc;

  assign w_sec_wrap  = (r_sec  == SEC_LAST);
  assign w_min_wrap  = (r_min  == MIN_LAST);
  assign w_hour_wrap = (r_hour == HOUR_LAST);

  // Wrapping increments, shared by tick advance and per-field adjust.
  assign w_sec_inc  = w_sec_wrap  ? '0 : r_sec  + SEC_BIT'(1);
  assign w_min_inc  = w_min_wrap  ? '0 : r_min  + MIN_BIT'(1);
  assign w_hour_inc = w_hour_wrap ? '0 : r_hour + HOUR_BIT'(1);

  assign w_sec_val  = set_val[SEC_BIT-1:0];
  assign w_min_val  = set_val[MIN_BIT-1:0];
  assign w_hour_val = set_val[HOUR_BIT-1:0];

  // Load is accepted only for a real field and a truncated value within range.
  always_comb begin
    w_load_ok = 1'b0;
    case (set_sel)
      SEL_SEC:  w_load_ok = (w_sec_val  <= SEC_LAST);
      SEL_MIN:  w_load_ok = (w_min_val  <= MIN_LAST);
      SEL_HOUR: w_load_ok = (w_hour_val <= HOUR_LAST);
      default:  w_load_ok = 1'b0;
    endcase
  end

  // Counter fields and carry/error pulses; priority reset > load > adjust > tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_set_err   <= 1'b0;
      if (set_en) begin
        if (w_load_ok) begin
          case (set_sel)
            SEL_SEC:  r_sec  <= w_sec_val;
            SEL_MIN:  r_min  <= w_min_val;
            SEL_HOUR: r_hour <= w_hour_val;
            default:  ;
          endcase
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (adj_inc) begin
        case (set_sel)
          SEL_SEC:  r_sec  <= w_sec_inc;
          SEL_MIN:  r_min  <= w_min_inc;
          SEL_HOUR: r_hour <= w_hour_inc;
          default:  ;
        endcase
      end else if (w_adv) begin
        // Whole cascade resolves in one edge; pulses line up with new values.
        r_sec      <= w_sec_inc;
        r_min_tick <= w_sec_wrap;
        if (w_sec_wrap) begin
          r_min       <= w_min_inc;
          r_hour_tick <= w_min_wrap;
          if (w_min_wrap) begin
            r_hour     <= w_hour_inc;
            r_day_tick <= w_hour_wrap;
          end
        end
      end
    end
  end

  // Display hour: identity in 24h mode, 1..HALF in 12h mode.
  always_comb begin
    w_h12     = r_hour % HALF_H;
    hour_disp = r_hour;
    if (mode_12h) begin
      hour_disp = (w_h12 == '0) ? HALF_H : w_h12;
    end
  end

  assign pm        = (r_hour >= HALF_H);
  assign sec       = r_sec;
  assign minute    = r_min;
  assign hour      = r_hour;
  assign min_tick  = r_min_tick;
  assign hour_tick = r_hour_tick;
  assign day_tick  = r_day_tick;
  assign set_err   = r_set_err;

endmodule

// File: tb/tb_tod_counter.sv
// Self-checking bench for tod_counter: directed scenarios plus randomized
// traffic, checked every cycle against a seconds-of-day reference model.
module tb_tod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       run;
  logic       mode_12h;
  logic       set_en;
  logic [1:0] set_sel;
  logic [5:0] set_val;
  logic       adj_inc;
  logic [5:0] sec;
  logic [5:0] minute;
  logic [4:0] hour;
  logic [4:0] hour_disp;
  logic       pm;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       set_err;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  int m_s, m_m, m_h;
  bit m_mt, m_ht, m_dt, m_err;

  always #5 clk = ~clk;

  tod_counter #(
    .SEC_BIT (6),
    .MIN_BIT (6),
    .HOUR_BIT(5),
    .SEC_MAX (59),
    .MIN_MAX (59),
    .HOUR_MAX(23)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .run      (run),
    .mode_12h (mode_12h),
    .set_en   (set_en),
    .set_sel  (set_sel),
    .set_val  (set_val),
    .adj_inc  (adj_inc),
    .sec      (sec),
    .minute   (minute),
    .hour     (hour),
    .hour_disp(hour_disp),
    .pm       (pm),
    .min_tick (min_tick),
    .hour_tick(hour_tick),
    .day_tick (day_tick),
    .set_err  (set_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference update for one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    int t, v, mx;
    m_mt = 0; m_ht = 0; m_dt = 0; m_err = 0;
    if (reset) begin
      m_s = 0; m_m = 0; m_h = 0;
    end else if (set_en) begin
      if (set_sel == 2'd3) begin
        m_err = 1;
      end else begin
        v  = (set_sel == 2'd2) ? (int'(set_val) % 32) : int'(set_val);
        mx = (set_sel == 2'd2) ? 23 : 59;
        if (v > mx) m_err = 1;
        else if (set_sel == 2'd0) m_s = v;
        else if (set_sel == 2'd1) m_m = v;
        else m_h = v;
      end
    end else if (adj_inc) begin
      case (set_sel)
        2'd0: m_s = (m_s + 1) % 60;
        2'd1: m_m = (m_m + 1) % 60;
        2'd2: m_h = (m_h + 1) % 24;
        default: ;
      endcase
    end else if (tick_in && run) begin
      t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_s = t % 60;
      m_m = (t / 60) % 60;
      m_h = t / 3600;
      m_mt = (m_s == 0);
      m_ht = (m_s == 0) && (m_m == 0);
      m_dt = (t == 0);
    end
  endtask

  task automatic check_all();
    int d;
    d = mode_12h ? (((m_h % 12) == 0) ? 12 : (m_h % 12)) : m_h;
    check_eq("sec",       32'(sec),       32'(m_s));
    check_eq("minute",    32'(minute),    32'(m_m));
    check_eq("hour",      32'(hour),      32'(m_h));
    check_eq("hour_disp", 32'(hour_disp), 32'(d));
    check_eq("pm",        32'(pm),        32'(m_h >= 12));
    check_eq("min_tick",  32'(min_tick),  32'(m_mt));
    check_eq("hour_tick", 32'(hour_tick), 32'(m_ht));
    check_eq("day_tick",  32'(day_tick),  32'(m_dt));
    check_eq("set_err",   32'(set_err),   32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; tick_in = 0; set_en = 0; adj_inc = 0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [5:0] val);
    set_en = 1; set_sel = sel; set_val = val;
    cyc();
    set_en = 0;
  endtask

  int nmt;
  int hsweep [6] = '{0, 1, 11, 12, 13, 23};
  int dsweep [6] = '{12, 1, 11, 12, 1, 11};
  int psweep [6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    reset = 1; tick_in = 0; run = 1; mode_12h = 0;
    set_en = 0; set_sel = 0; set_val = 0; adj_inc = 0;
    m_s = 0; m_m = 0; m_h = 0;
    cyc();
    cyc();
    reset = 0;
    check_eq("rst_sec", 32'(sec), 0);
    check_eq("rst_disp24", 32'(hour_disp), 0);
    mode_12h = 1; #1;
    check_eq("rst_disp12", 32'(hour_disp), 12);
    check_eq("rst_pm", 32'(pm), 0);
    mode_12h = 0;

    // 60 ticks: one minute
    nmt = 0;
    for (int i = 0; i < 60; i++) begin
      tick_in = 1;
      cyc();
      if (min_tick) nmt++;
      if (i == 59) begin
        check_eq("sec_wrap", 32'(sec), 0);
        check_eq("min_tick_at_wrap", 32'(min_tick), 1);
      end
    end
    tick_in = 0;
    cyc();
    check_eq("minute_one", 32'(minute), 1);
    check_eq("min_tick_count", 32'(nmt), 1);

    // full rollover
    load(2'd0, 6'd59); load(2'd1, 6'd59); load(2'd2, 6'd23);
    tick_in = 1; cyc(); tick_in = 0;
    check_eq("roll_hour", 32'(hour), 0);
    check_eq("roll_ticks", 32'({min_tick, hour_tick, day_tick}), 32'h7);
    cyc();
    check_eq("roll_ticks_low", 32'({min_tick, hour_tick, day_tick}), 0);

    // pause, rejected loads
    load(2'd0, 6'd17);
    run = 0;
    for (int i = 0; i < 10; i++) begin tick_in = 1; cyc(); end
    tick_in = 0; run = 1;
    check_eq("pause_sec", 32'(sec), 17);
    load(2'd0, 6'd60);
    check_eq("err_range", 32'(set_err), 1);
    check_eq("err_sec_kept", 32'(sec), 17);
    cyc();
    check_eq("err_pulse_low", 32'(set_err), 0);
    load(2'd3, 6'd5);
    check_eq("err_sel3", 32'(set_err), 1);
    cyc();

    // adjust wrap without carry; tick dropped against adjust
    load(2'd2, 6'd23);
    adj_inc = 1; set_sel = 2'd2; cyc(); adj_inc = 0;
    check_eq("adj_hour_wrap", 32'(hour), 0);
    check_eq("adj_no_day_tick", 32'(day_tick), 0);
    load(2'd0, 6'd5);
    adj_inc = 1; tick_in = 1; set_sel = 2'd0; cyc(); idle();
    check_eq("adj_tick_drop", 32'(sec), 6);

    // 12h sweep
    mode_12h = 1;
    for (int i = 0; i < 6; i++) begin
      load(2'd2, 6'(hsweep[i]));
      check_eq("disp12", 32'(hour_disp), 32'(dsweep[i]));
      check_eq("pm12", 32'(pm), 32'(psweep[i]));
    end
    mode_12h = 0;

    // reset beats a rollover tick
    load(2'd0, 6'd59); load(2'd1, 6'd59); load(2'd2, 6'd23);
    reset = 1; tick_in = 1; cyc(); idle();
    check_eq("rst_over_tick", 32'({sec, minute, hour}), 0);
    check_eq("rst_no_pulses", 32'({min_tick, hour_tick, day_tick}), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      set_en  = ($urandom_range(0, 9) == 0);
      adj_inc = ($urandom_range(0, 9) == 0);
      tick_in = ($urandom_range(0, 1) == 1);
      run     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
      set_sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: set_val = (set_sel == 2'd2) ? 6'd23 : 6'd59;
        1: set_val = 6'($urandom_range(0, 63));
        default: set_val = 6'($urandom_range(55, 63));
      endcase
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tod_counter.md
Name: tod_counter

Overview:
- Parametrised time-of-day counter: seconds, minutes and hours, advanced by a one-cycle seconds tick from the upstream tick generator.
- Adds field load, per-field adjust (increment without carry), run/pause, a 12/24-hour display mode and registered carry pulses.
- Sits between the tick generator and the display/alarm logic; successor to the fixed 60/60/24 counter chain.

Parameters:
- SEC_BIT, 6, width of sec field
- MIN_BIT, 6, width of minute field
- HOUR_BIT, 5, width of hour field
- SEC_MAX, 59, terminal count of seconds (must be < 2**SEC_BIT)
- MIN_MAX, 59, terminal count of minutes (must be < 2**MIN_BIT)
- HOUR_MAX, 23, terminal count of hours; must be odd and >= 3 for 12h mode

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tick_in  in  1  one-cycle seconds advance pulse
- run  in  1  1 = count on tick_in, 0 = paused
- mode_12h  in  1  1 = 12-hour display encoding on hour_disp
- set_en  in  1  load strobe, one cycle
- set_sel  in  2  field select: 0 = sec, 1 = minute, 2 = hour, 3 = reserved
- set_val  in  max(SEC_BIT,MIN_BIT,HOUR_BIT)  load value
- adj_inc  in  1  adjust strobe: increment the field selected by set_sel
- sec  out  SEC_BIT  seconds count
- minute  out  MIN_BIT  minutes count
- hour  out  HOUR_BIT  internal hours count, 0..HOUR_MAX
- hour_disp  out  HOUR_BIT  display hour: equals hour in 24h mode; 12h mapping below
- pm  out  1  1 when hour > HOUR_MAX/2 (valid in both modes)
- min_tick  out  1  registered pulse: seconds wrapped
- hour_tick  out  1  registered pulse: minutes wrapped
- day_tick  out  1  registered pulse: hours wrapped
- set_err  out  1  registered pulse: rejected load

Behaviour:
- Reset: sec, minute and hour = 0; all pulse outputs = 0. After reset, hour_disp = 0 in 24h mode and 12 in 12h mode, with pm = 0.
- Priority per cycle: reset > set_en > adj_inc > tick advance. A tick_in arriving with set_en or adj_inc is dropped, not deferred.
- Advance: occurs when tick_in && run && !set_en && !adj_inc.
  - sec increments; at SEC_MAX it wraps to 0 and minute increments.
  - minute at MIN_MAX wraps to 0 and hour increments.
  - hour at HOUR_MAX wraps to 0.
  - The full cascade (59:59:23 -> 0:0:0) completes in a single clock.
- Pulses:
  - min_tick, hour_tick and day_tick are high exactly one cycle: the cycle after the update that produced the wrap. They coincide with the first cycle the new values are visible.
  - On a full rollover, all three are high together.
- Pause: run = 0 ignores tick_in. Load and adjust still operate.
- Load: set_en with set_sel in 0..2 writes set_val, truncated to the field width, into the selected field on the next edge.
  - If the value exceeds the field MAX or set_sel = 3: no field changes, and set_err pulses one cycle.
  - A load generates no carry pulses.
- Adjust: adj_inc increments the selected field by one, wrapping MAX -> 0 with no carry into the next field and no carry pulses. set_sel = 3 is ignored silently.
- 12h mapping:
  - h12 = hour mod ((HOUR_MAX+1)/2).
  - hour_disp = (h12 == 0) ? (HOUR_MAX+1)/2 : h12.
  - Combinational from hour and mode_12h. Changing mode_12h affects only hour_disp, never the count.
- Reset mid-operation: overrides everything in the same cycle. Pulses pending from the previous cycle are cleared.
- Arithmetic: all comparisons use unsigned values at field width. No field ever holds a value > its MAX.

Test Plan:
- Reset then 60 tick_in with run = 1 -> sec counts 0..59 then 0; minute = 1; min_tick high for exactly one cycle, when sec first reads 0.
- Load sec = 59, minute = 59, hour = 23, then one tick_in -> all fields 0 on the next cycle; min_tick, hour_tick and day_tick all high that cycle, then low.
- run = 0 with 10 tick_in -> no change. Assert set_en with set_sel = 0 and set_val = 60 -> sec unchanged, set_err one-cycle pulse. set_sel = 3 -> set_err pulse.
- hour = 23, adj_inc with set_sel = 2 -> hour = 0, day_tick stays 0. Same-cycle tick_in and adj_inc on sec = 5 -> sec = 6 (tick dropped).
- mode_12h = 1, sweep hour 0, 1, 11, 12, 13, 23 -> hour_disp 12, 1, 11, 12, 1, 11; pm 0, 0, 0, 1, 1, 1.
- Assert reset in the same cycle as tick_in at 23:59:59 -> fields 0, no pulses asserted next cycle.
